button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner_pkg.sv | 28 ++
 rtl/button_conditioner_debounce_cell.sv | 56 +++++
 rtl/button_conditioner.sv | 100 ++++++++++
 tb/tb_button_conditioner.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared types and constants for the button conditioner.
//   color_t        : colour code carried on color_code / color_raw bit index
//   BTN_*          : bit positions of each button in the internal raw vector
//   DEBOUNCE_CYCLES_DEFAULT : 10 ms at 50 MHz
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    RED    = 2'd1,
    YELLOW = 2'd2,
    BLUE   = 2'd3
  } color_t;

  localparam int unsigned BTN_GREEN      = 0;
  localparam int unsigned BTN_RED        = 1;
  localparam int unsigned BTN_YELLOW     = 2;
  localparam int unsigned BTN_BLUE       = 3;
  localparam int unsigned BTN_SPEED      = 4;
  localparam int unsigned BTN_DIFFICULTY = 5;
  localparam int unsigned BTN_MODE       = 6;
  localparam int unsigned BTN_START      = 7;

  localparam int unsigned NUM_COLORS  = 4;
  localparam int unsigned NUM_BUTTONS = 8;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500_000;

endpackage

// File: rtl/button_conditioner_debounce_cell.sv
// One button channel: 2-flop synchronizer, persistence counter and debounced
// level.
//   clk, rst_ : clock, asynchronous active-low reset
//   i_raw     : raw asynchronous button level
//   o_stable  : debounced level
//   o_rise    : high on the cycle whose rising edge sets o_stable 0->1
module debounce_cell
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_,
  input  logic i_raw,
  output logic o_stable,
  output logic o_rise
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          w_done;

  // The differing level has persisted long enough; it is accepted this edge.
  assign w_done = (r_sync2 != r_stable) && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_stable) begin
        if (w_done) begin
          r_stable <= r_sync2;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_stable = r_stable;
  assign o_rise   = w_done & r_sync2;

endmodule

// File: rtl/button_conditioner.sv
// Debounces four colour buttons and four settings/start buttons and turns
// presses into one-cycle strobes. Colour presses are encoded to a 2-bit code
// with a collision flag. Strobes are suppressed while enable is low.
//   clk, rst_             : clock, asynchronous active-low reset
//   enable                : 1 = report presses
//   color_raw[3:0]        : raw colour buttons (bit index = colour code)
//   speed/difficulty/mode/start_raw : raw settings and start buttons
//   color_valid/color_code: single colour press strobe and its code
//   color_err             : two or more colours pressed in the same cycle
//   *_pulse               : one-cycle press strobes
//   color_held[3:0]       : debounced colour levels
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       enable,
  input  logic [3:0] color_raw,
  input  logic       speed_raw,
  input  logic       difficulty_raw,
  input  logic       mode_raw,
  input  logic       start_raw,
  output logic       color_valid,
  output logic [1:0] color_code,
  output logic       color_err,
  output logic       speed_pulse,
  output logic       difficulty_pulse,
  output logic       mode_pulse,
  output logic       start_pulse,
  output logic [3:0] color_held
);

  logic [NUM_BUTTONS-1:0] w_raw;
  logic [NUM_BUTTONS-1:0] w_stable;
  logic [NUM_BUTTONS-1:0] w_rise;
  logic [NUM_BUTTONS-1:0] w_press;
  logic [2:0]             w_ncol;
  color_t                 w_idx;

  logic       r_valid;
  logic       r_err;
  color_t     r_code;
  logic [3:0] r_pulse;

  assign w_raw = {start_raw, mode_raw, difficulty_raw, speed_raw, color_raw};

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk     (clk),
      .rst_    (rst_),
      .i_raw   (w_raw[g]),
      .o_stable(w_stable[g]),
      .o_rise  (w_rise[g])
    );
  end

  // A press completes while the stable level is still low.
  assign w_press = w_rise & ~w_stable;

  always_comb begin
    w_ncol = '0;
    w_idx  = GREEN;
    for (int unsigned i = 0; i < NUM_COLORS; i++) begin
      if (w_press[i]) begin
        w_ncol = w_ncol + 3'd1;
        w_idx  = color_t'(i[1:0]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= GREEN;
      r_pulse <= '0;
    end else begin
      r_valid <= enable && (w_ncol == 3'd1);
      r_err   <= enable && (w_ncol >= 3'd2);
      if (enable && (w_ncol == 3'd1)) begin
        r_code <= w_idx;
      end
      r_pulse <= enable ? w_press[BTN_START:BTN_SPEED] : '0;
    end
  end

  assign color_valid      = r_valid;
  assign color_err        = r_err;
  assign color_code       = r_code;
  assign speed_pulse      = r_pulse[0];
  assign difficulty_pulse = r_pulse[1];
  assign mode_pulse       = r_pulse[2];
  assign start_pulse      = r_pulse[3];
  assign color_held       = w_stable[NUM_COLORS-1:0];

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic       enable = 1'b1;
  logic [3:0] color_raw = '0;
  logic       speed_raw = 1'b0;
  logic       difficulty_raw = 1'b0;
  logic       mode_raw = 1'b0;
  logic       start_raw = 1'b0;
  logic       color_valid;
  logic [1:0] color_code;
  logic       color_err;
  logic       speed_pulse;
  logic       difficulty_pulse;
  logic       mode_pulse;
  logic       start_pulse;
  logic [3:0] color_held;

  int n_pass = 0;
  int n_total = 0;

  button_conditioner #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk             (clk),
    .rst_            (rst_),
    .enable          (enable),
    .color_raw       (color_raw),
    .speed_raw       (speed_raw),
    .difficulty_raw  (difficulty_raw),
    .mode_raw        (mode_raw),
    .start_raw       (start_raw),
    .color_valid     (color_valid),
    .color_code      (color_code),
    .color_err       (color_err),
    .speed_pulse     (speed_pulse),
    .difficulty_pulse(difficulty_pulse),
    .mode_pulse      (mode_pulse),
    .start_pulse     (start_pulse),
    .color_held      (color_held)
  );

  always #5 clk = ~clk;

  // Reference model: a level is accepted once the last DB synchronized
  // samples all differ from the accepted level. Synchronized sample at edge k
  // is the raw level sampled at edge k-2, so hist[b][d] holds raw at edge k-d.
  bit       hist [8][DB+2];
  bit [7:0] m_stable;
  bit       m_valid, m_err;
  bit [1:0] m_code;
  bit [3:0] m_pulse;   // {start, mode, difficulty, speed}

  function automatic void model_reset();
    for (int b = 0; b < 8; b++)
      for (int d = 0; d < DB + 2; d++) hist[b][d] = 1'b0;
    m_stable = '0;
    m_valid = 1'b0;
    m_err = 1'b0;
    m_code = '0;
    m_pulse = '0;
  endfunction

  function automatic logic [11:0] obs();
    return {color_valid, color_code, color_err, start_pulse, mode_pulse,
            difficulty_pulse, speed_pulse, color_held};
  endfunction

  function automatic logic [11:0] expv();
    return {m_valid, m_code, m_err, m_pulse, m_stable[3:0]};
  endfunction

  task automatic tick();
    bit [7:0] r;
    bit [7:0] rise;
    bit       en;
    bit       all_diff;
    int       ncol;
    int       idx;
    @(posedge clk);
    if (!rst_) begin
      model_reset();
    end else begin
      r = {start_raw, mode_raw, difficulty_raw, speed_raw, color_raw};
      en = enable;
      rise = '0;
      for (int b = 0; b < 8; b++) begin
        for (int d = DB + 1; d > 0; d--) hist[b][d] = hist[b][d-1];
        hist[b][0] = r[b];
        all_diff = 1'b1;
        for (int d = 2; d <= DB + 1; d++)
          if (hist[b][d] == m_stable[b]) all_diff = 1'b0;
        if (all_diff) begin
          rise[b] = !m_stable[b];
          m_stable[b] = !m_stable[b];
        end
      end
      ncol = 0;
      idx = 0;
      for (int c = 0; c < 4; c++)
        if (rise[c]) begin
          ncol++;
          idx = c;
        end
      m_valid = en && (ncol == 1);
      m_err = en && (ncol >= 2);
      if (m_valid) m_code = idx[1:0];
      m_pulse = en ? rise[7:4] : 4'b0;
    end
    @(negedge clk);
  endtask

  task automatic release_all();
    color_raw = '0;
    speed_raw = 1'b0;
    difficulty_raw = 1'b0;
    mode_raw = 1'b0;
    start_raw = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    model_reset();
    n_total++;
    if (obs() !== 12'h000) $display("FAIL reset_state: got %h want %h", obs(), 12'h000);
    else n_pass++;
    tick();
    tick();
    rst_ = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++;
      if (obs() !== expv()) $display("FAIL reset_idle: got %h want %h", obs(), expv());
      else n_pass++;
    end
  endtask

  task automatic test_start_press();
    int first = 0;
    int count = 0;
    start_raw = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (start_pulse) begin
        count++;
        if (first == 0) first = e;
      end
      n_total++;
      if (obs() !== expv()) $display("FAIL start_model cyc%0d: got %h want %h", e, obs(), expv());
      else n_pass++;
    end
    n_total++;
    if (first != DB + 2) $display("FAIL start_latency: got edge %0d want %0d", first, DB + 2);
    else n_pass++;
    n_total++;
    if (count != 1) $display("FAIL start_once: got %0d pulses want 1", count);
    else n_pass++;
    release_all();
    for (int e = 0; e < 10; e++) begin
      tick();
      n_total++;
      if (obs() !== expv()) $display("FAIL start_release: got %h want %h", obs(), expv());
      else n_pass++;
    end
  endtask

  task automatic test_color_single();
    int seen = 0;
    color_raw = 4'b0100;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (color_valid) begin
        seen++;
        n_total++;
        if (color_code !== 2'd2) $display("FAIL color_code: got %0d want 2", color_code);
        else n_pass++;
      end
      n_total++;
      if (obs() !== expv()) $display("FAIL color_single: got %h want %h", obs(), expv());
      else n_pass++;
    end
    n_total++;
    if (seen != 1) $display("FAIL color_valid_once: got %0d want 1", seen);
    else n_pass++;
    release_all();
    for (int e = 0; e < 10; e++) begin
      tick();
      n_total++;
      if (obs() !== expv()) $display("FAIL color_release: got %h want %h", obs(), expv());
      else n_pass++;
    end
  endtask

  task automatic test_color_multi();
    int errs = 0;
    color_raw = 4'b1001;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (color_err) errs++;
      n_total++;
      if (obs() !== expv()) $display("FAIL color_multi: got %h want %h", obs(), expv());
      else n_pass++;
    end
    n_total++;
    if (errs != 1) $display("FAIL color_err_once: got %0d want 1", errs);
    else n_pass++;
    release_all();
    for (int e = 0; e < 10; e++) tick();
  endtask

  task automatic test_glitch();
    int pulses = 0;
    speed_raw = 1'b1;
    for (int e = 0; e < 3; e++) begin
      tick();
      n_total++;
      if (obs() !== expv()) $display("FAIL glitch_hi: got %h want %h", obs(), expv());
      else n_pass++;
    end
    speed_raw = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick();
      if (speed_pulse) pulses++;
      n_total++;
      if (obs() !== expv()) $display("FAIL glitch_lo: got %h want %h", obs(), expv());
      else n_pass++;
    end
    n_total++;
    if (pulses != 0) $display("FAIL glitch_no_strobe: got %0d want 0", pulses);
    else n_pass++;
    // A fresh press after the glitch must still need the full persistence.
    speed_raw = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      n_total++;
      if (obs() !== expv()) $display("FAIL glitch_repress: got %h want %h", obs(), expv());
      else n_pass++;
    end
    release_all();
    for (int e = 0; e < 10; e++) tick();
  endtask

  task automatic test_enable();
    int pulses = 0;
    enable = 1'b0;
    mode_raw = 1'b1;
    for (int e = 0; e < 16; e++) begin
      if (e == 8) enable = 1'b1;
      tick();
      if (mode_pulse) pulses++;
      n_total++;
      if (obs() !== expv()) $display("FAIL enable_gate: got %h want %h", obs(), expv());
      else n_pass++;
    end
    n_total++;
    if (pulses != 0) $display("FAIL enable_dropped: got %0d want 0", pulses);
    else n_pass++;
    release_all();
    for (int e = 0; e < 10; e++) tick();
  endtask

  task automatic test_reset_mid();
    int first = 0;
    difficulty_raw = 1'b1;
    for (int e = 0; e < 4; e++) tick();
    rst_ = 1'b0;
    #1;
    model_reset();
    n_total++;
    if (obs() !== 12'h000) $display("FAIL reset_async: got %h want %h", obs(), 12'h000);
    else n_pass++;
    tick();
    tick();
    rst_ = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (difficulty_pulse && first == 0) first = e;
      n_total++;
      if (obs() !== expv()) $display("FAIL reset_mid_model: got %h want %h", obs(), expv());
      else n_pass++;
    end
    n_total++;
    if (first != DB + 2) $display("FAIL reset_mid_latency: got edge %0d want %0d", first, DB + 2);
    else n_pass++;
    release_all();
    for (int e = 0; e < 10; e++) tick();
  endtask

  task automatic test_random();
    int hold [8];
    bit [7:0] lvl;
    lvl = '0;
    for (int b = 0; b < 8; b++) hold[b] = 0;
    for (int e = 0; e < 600; e++) begin
      for (int b = 0; b < 8; b++) begin
        if (hold[b] == 0) begin
          lvl[b] = 1'($urandom_range(0, 1));
          hold[b] = int'($urandom_range(1, 10));
        end
        hold[b]--;
      end
      color_raw = lvl[3:0];
      speed_raw = lvl[4];
      difficulty_raw = lvl[5];
      mode_raw = lvl[6];
      start_raw = lvl[7];
      if ($urandom_range(0, 9) == 0) enable = !enable;
      tick();
      n_total++;
      if (obs() !== expv()) $display("FAIL random cyc%0d: got %h want %h", e, obs(), expv());
      else n_pass++;
    end
    enable = 1'b1;
    release_all();
    for (int e = 0; e < 10; e++) tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start_press();
    test_color_single();
    test_color_multi();
    test_glitch();
    test_enable();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
